// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - self-test sequencer sweeping AND/OR/NOT gates through their truth table
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_mask,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic [2:0] r_mask;
  logic       r_a;
  logic       r_b;
  logic       r_pass;
  logic [3:0] r_err;
  logic [2:0] r_fail;

  logic       w_accept;
  logic       w_settled;
  logic       w_last;
  logic [2:0] w_golden;
  logic [2:0] w_miss;
  logic [1:0] w_nmiss;
  logic [4:0] w_err_sum;
  logic [3:0] w_err_next;
  logic [1:0] w_vec_inc;

  // Golden values are taken from the operands currently driven, bit order matches op_mask
  assign w_golden   = {~r_a, r_a | r_b, r_a & r_b};
  assign w_miss     = ({y_not, y_or, y_and} ^ w_golden) & r_mask;
  assign w_nmiss    = {1'b0, w_miss[0]} + {1'b0, w_miss[1]} + {1'b0, w_miss[2]};
  assign w_err_sum  = {1'b0, r_err} + {3'b000, w_nmiss};
  assign w_err_next = w_err_sum[4] ? 4'hF : w_err_sum[3:0];
  assign w_vec_inc  = r_vec + 2'd1;
  assign w_settled  = (r_cnt == 4'(SETTLE_CYCLES - 1));
  assign w_last     = (r_vec == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        w_accept = start;
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settled) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_next = w_last ? S_DONE : S_SETTLE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= 2'd0;
      r_cnt  <= 4'd0;
      r_mask <= 3'd0;
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= 4'd0;
      r_fail <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mask <= op_mask;
            r_err  <= 4'd0;
            r_fail <= 3'd0;
            r_pass <= 1'b0;
            r_vec  <= 2'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_cnt  <= 4'd0;
          end
        end
        S_SETTLE: begin
          if (!w_settled) r_cnt <= r_cnt + 4'd1;
        end
        S_SAMPLE: begin
          r_fail <= r_fail | w_miss;
          r_err  <= w_err_next;
          if (w_last) begin
            r_pass <= (w_err_next == 4'd0);
          end else begin
            r_vec  <= w_vec_inc;
            r_a    <= w_vec_inc[1];
            r_b    <= w_vec_inc[0];
            r_cnt  <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - scoreboard bench for gate_sweep_ctrl with faultable gate models
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_mask;
  logic       y_and, y_or, y_not;
  logic       a, b, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int fault_mode = 0;

  typedef struct {
    int         start_edge;
    logic [3:0] err;
    logic [2:0] fail;
    logic       pass;
  } exp_t;
  exp_t q[$];

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mask(op_mask),
    .y_and(y_and), .y_or(y_or), .y_not(y_not),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 good, 1 AND stuck at 0, 2 NOT non-inverting, 3 all outputs inverted
  always_comb begin
    y_and = a & b;
    y_or  = a | b;
    y_not = ~a;
    case (fault_mode)
      1: y_and = 1'b0;
      2: y_not = a;
      3: begin y_and = ~(a & b); y_or = ~(a | b); y_not = a; end
      default: ;
    endcase
  end

  function automatic void check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: follows the sweep at the head of the scoreboard and checks it on every falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0) begin
        int t;
        t = cyc - q[0].start_edge;
        if (t >= 0 && t <= 12) begin
          check("ab_vector", {a, b}, (t < 12) ? t / 3 : 3);
          check("busy", busy, 1);
        end
        if (done) begin
          check("done_latency", t, 12);
          check("err_count", err_count, q[0].err);
          check("fail_vec", fail_vec, q[0].fail);
          check("pass", pass, q[0].pass);
          void'(q.pop_front());
        end
      end else if (done) begin
        check("unexpected_done", 1, 0);
      end
    end
  end

  task automatic run_sweep(input logic [2:0] mask, input int fault, input logic [3:0] e_err,
                           input logic [2:0] e_fail, input logic e_pass, input bit pulse_again);
    exp_t e;
    @(negedge clk);
    fault_mode = fault;
    op_mask    = mask;
    start      = 1'b1;
    e.start_edge = cyc + 1;
    e.err  = e_err;
    e.fail = e_fail;
    e.pass = e_pass;
    q.push_back(e);
    @(posedge clk); #1;
    start   = 1'b0;
    op_mask = ~mask;
    if (pulse_again) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    check("sweep_timeout", q.size(), 0);
    q.delete();
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_mask = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fail", fail_vec, 0);
    check("rst_ab", {a, b}, 0);
    @(negedge clk) rst = 1'b0;

    run_sweep(3'b111, 0, 4'd0,  3'b000, 1'b1, 1'b0);
    run_sweep(3'b111, 1, 4'd1,  3'b001, 1'b0, 1'b0);
    run_sweep(3'b111, 2, 4'd4,  3'b100, 1'b0, 1'b0);
    run_sweep(3'b011, 2, 4'd0,  3'b000, 1'b1, 1'b0);
    run_sweep(3'b111, 3, 4'd12, 3'b111, 1'b0, 1'b0);
    run_sweep(3'b000, 3, 4'd0,  3'b000, 1'b1, 1'b0);
    run_sweep(3'b111, 0, 4'd0,  3'b000, 1'b1, 1'b1);
    check("pass_held", pass, 1);

    // Abort during SAMPLE of v=2 (eighth edge after the accepting edge)
    @(negedge clk);
    fault_mode = 1;
    op_mask = 3'b111;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_abort_ab", {a, b}, 2);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ab", {a, b}, 0);
    check("abort_err", err_count, 0);
    check("abort_fail", fail_vec, 0);
    @(negedge clk) rst = 1'b0;
    repeat (16) @(negedge clk) check("no_done_after_abort", done, 0);

    run_sweep(3'b111, 0, 4'd0, 3'b000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that drives the shared basic-gate datapath (AND, OR and NOT dataflow gates) through its full 2-input truth table and checks each gate against golden values.
- Owns the a/b operand lines of the gate instances.
- Waits a programmable settle time per vector, then samples y_and/y_or/y_not.
- Reports per-gate sticky failures, an error count and a pass flag.
- Sits beside the gate instances as a self-test controller, replacing hand-written initial-block stimulus.

Parameters:
SETTLE_CYCLES, 2, number of clock cycles operands are held before the gate outputs are sampled (legal range 1..15).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a sweep; sampled only in IDLE.
op_mask  input  3  gate enable for checking: bit0 AND, bit1 OR, bit2 NOT; latched at start.
y_and  input  1  output of the AND gate under test.
y_or  input  1  output of the OR gate under test.
y_not  input  1  output of the NOT gate under test (driven from a).
a  output  1  operand a to all gates.
b  output  1  operand b to AND/OR gates.
busy  output  1  high while a sweep is in progress, including the DONE cycle.
done  output  1  one-cycle pulse marking sweep completion.
pass  output  1  1 when the last sweep had zero errors; held until the next accepted start.
err_count  output  4  number of mismatches in the last or current sweep; maximum 12.
fail_vec  output  3  sticky per-gate failure flags, same bit order as op_mask.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Vector index = 0, settle counter = 0.
  - Reset mid-sweep abandons the sweep with no done pulse.
- States:
  - IDLE. Only state that accepts start. Otherwise a/b, pass, err_count and fail_vec hold.
  - SETTLE. Counter counts up; after SETTLE_CYCLES cycles, go to SAMPLE.
  - SAMPLE. One cycle; compare enabled gates against golden values.
  - DONE. One cycle; done=1, then return to IDLE.
- IDLE + start=1, at the clock edge:
  - Latch op_mask.
  - Set err_count=0, fail_vec=0, pass=0.
  - Set vector v=0, a=v[1], b=v[0].
  - Counter = 0, busy=1, go to SETTLE.
- Vector order: v=0..3 gives (a,b) = 00, 01, 10, 11.
- Golden values: AND = a&b, OR = a|b, NOT = ~a.
- Comparison in SAMPLE:
  - Uses the a/b currently driven and the y_* inputs sampled in that cycle.
  - For each enabled gate with a mismatch: set its fail_vec bit.
  - err_count += number of mismatching enabled gates (0..3), saturating at 15. This cannot be reached in practice: max 12.
- Leaving SAMPLE:
  - v<3: v++, drive the new a/b, counter=0, go to SETTLE.
  - v==3: pass <= (final err_count==0), including this cycle's errors; go to DONE.
- Timing, with edge 1 = the edge that accepts start:
  - SAMPLE for vector k occurs after edge 1 + S + k·(S+1), where S = SETTLE_CYCLES.
  - DONE (done=1) occurs after edge 4S+5; with S=2 that is edge 13.
  - busy falls after edge 4S+6.
- start while busy (SETTLE/SAMPLE/DONE): ignored, no queuing.
- start held high continuously: a new sweep begins on the first edge in IDLE after DONE.
- op_mask=0: sweep runs normally, err_count=0, pass=1.
- op_mask changes mid-sweep: no effect; the latched copy is used.
- After DONE: a/b remain at 1/1 until the next start or reset.

Test Plan:
- Correct gates, op_mask=111, S=2, one-cycle start → a/b sequence 00,01,10,11, each held 3 cycles; done pulse after edge 13; pass=1, err_count=0, fail_vec=000.
- y_and tied to 0, op_mask=111 → single mismatch at v=3; err_count=1, fail_vec=001, pass=0.
- y_not wired to a (non-inverting), op_mask=111 → err_count=4, fail_vec=100, pass=0; rerun with op_mask=011 → err_count=0, pass=1.
- All three gate outputs inverted, op_mask=111 → err_count=12, fail_vec=111, pass=0.
- Pulse start again during SETTLE of v=1 → ignored; exactly one done pulse, timing unchanged from the first scenario.
- Assert rst during SAMPLE of v=2 → outputs zero immediately, no done; then start → a clean full sweep with pass=1.
